pmod_link_scheduler: RTL and testbench

- Master-side sequencer for the serial PMOD score link that feeds the two-digit seven-segment slave board.
- Shares one serial lane between two requesters (lane/player 0 and lane/player 1) using 2-way round-robin arbitration.
- Frames each granted byte as a 9-bit word: bit 0 is the source tag, bits 1..8 are data, LSB first.
- Shifts the word out at a programmable bit rate, then enforces an idle gap so the receiver can realign.

---
 rtl/pmod_link_scheduler_pkg.sv | 22 ++
 rtl/pmod_link_scheduler_rr_arbiter2.sv | 31 +++
 rtl/pmod_link_scheduler.sv | 134 +++++++++++++
 tb/tb_pmod_link_scheduler.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmod_link_scheduler_pkg.sv
// Shared definitions for the PMOD score link (master scheduler and slave receiver).
package pmod_link_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } link_state_t;

   localparam int unsigned DEF_DATA_W       = 8;
   localparam int unsigned DEF_CLKS_PER_BIT = 2;
   localparam int unsigned DEF_GAP_BITS     = 4;

   // Frame = source tag followed by payload, LSB first.
   localparam int unsigned FRAME_W = DEF_DATA_W + 1;
   localparam int unsigned TAG_POS = 0;

   function automatic int unsigned frame_width(input int unsigned data_w);
      return data_w + 1;
   endfunction

endpackage

// File: rtl/pmod_link_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, registered last-grant memory.
module rr_arbiter2
   import pmod_link_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic req0,
   input  logic req1,
   input  logic grant_en,
   output logic grant0,
   output logic grant1
);

   logic last_grant;

   // Lone requester wins; on a tie the requester not served last wins.
   always_comb begin
      grant0 = req0 & (~req1 | last_grant);
      grant1 = req1 & (~req0 | ~last_grant);
   end

   // Remember who was served so the next tie goes the other way; reset favours requester 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= 1'b1;
      end else if (grant_en) begin
         last_grant <= grant1;
      end
   end

endmodule

// File: rtl/pmod_link_scheduler.sv
// PMOD score-link master: arbitrates two byte requesters, serialises a tagged frame, then idles a gap.
module pmod_link_scheduler
   import pmod_link_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int unsigned DATA_W       = DEF_DATA_W,
   parameter int unsigned GAP_BITS     = DEF_GAP_BITS
) (
   input  logic              i_Clk,
   input  logic              i_Rst,
   input  logic              i_Req0,
   input  logic [DATA_W-1:0] i_Data0,
   output logic              o_Ack0,
   input  logic              i_Req1,
   input  logic [DATA_W-1:0] i_Data1,
   output logic              o_Ack1,
   output logic              o_Pmod_Data,
   output logic              o_Pmod_Frame,
   output logic              o_Busy
);

   localparam int unsigned FW      = frame_width(DATA_W);
   localparam int unsigned BIT_W   = $clog2(DATA_W + 2);
   localparam int unsigned DIV_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned GAP_CYC = GAP_BITS * CLKS_PER_BIT;
   localparam int unsigned GAP_W   = $clog2(GAP_CYC + 1);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FW - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

   link_state_t       state;
   logic [FW-1:0]     shreg;
   logic [BIT_W-1:0]  bit_cnt;
   logic [DIV_W-1:0]  div_cnt;
   logic [GAP_W-1:0]  gap_cnt;
   logic              ack0;
   logic              ack1;
   logic              frame;
   logic              busy;

   logic              grant_en;
   logic              win0;
   logic              win1;
   logic [FW-1:0]     load_word;

   assign grant_en = (state == ST_IDLE) && (i_Req0 || i_Req1);

   rr_arbiter2 u_arb (
      .clk      (i_Clk),
      .rst      (i_Rst),
      .req0     (i_Req0),
      .req1     (i_Req1),
      .grant_en (grant_en),
      .grant0   (win0),
      .grant1   (win1)
   );

   // Assemble the frame for whichever requester the arbiter picked.
   always_comb begin
      load_word          = '0;
      load_word[FW-1:1]  = win1 ? i_Data1 : i_Data0;
      load_word[TAG_POS] = win1;
   end

   // Link sequencer: the shift register's LSB is the bit on the wire, so clearing it silences the pin.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state   <= ST_IDLE;
         shreg   <= '0;
         bit_cnt <= '0;
         div_cnt <= '0;
         gap_cnt <= '0;
         ack0    <= 1'b0;
         ack1    <= 1'b0;
         frame   <= 1'b0;
         busy    <= 1'b0;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (grant_en) begin
                  shreg   <= load_word;
                  bit_cnt <= '0;
                  div_cnt <= '0;
                  ack0    <= win0;
                  ack1    <= win1;
                  frame   <= 1'b1;
                  busy    <= 1'b1;
                  state   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  if (bit_cnt == BIT_LAST) begin
                     shreg   <= '0;
                     frame   <= 1'b0;
                     gap_cnt <= '0;
                     state   <= ST_GAP;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     shreg   <= shreg >> 1;
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            ST_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: begin
               shreg <= '0;
               frame <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_Ack0       = ack0;
   assign o_Ack1       = ack1;
   assign o_Pmod_Data  = shreg[0];
   assign o_Pmod_Frame = frame;
   assign o_Busy       = busy;

endmodule

// File: tb/tb_pmod_link_scheduler.sv
// Bench for pmod_link_scheduler: default-rate instance plus a CLKS_PER_BIT=1/GAP_BITS=1 instance.
module tb_pmod_link_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic [7:0] data0 = '0, data1 = '0;
   logic       ack0, ack1, pdata, pframe, busy;

   logic       f_req0 = 1'b0, f_req1 = 1'b0;
   logic [7:0] f_data0 = '0, f_data1 = '0;
   logic       f_ack0, f_ack1, f_pdata, f_pframe, f_busy;

   int tests_run = 0;
   int tests_failed = 0;
   int model_last = 1;

   always #5 clk = ~clk;

   pmod_link_scheduler #(.CLKS_PER_BIT(2), .DATA_W(8), .GAP_BITS(4)) dut (
      .i_Clk(clk), .i_Rst(rst),
      .i_Req0(req0), .i_Data0(data0), .o_Ack0(ack0),
      .i_Req1(req1), .i_Data1(data1), .o_Ack1(ack1),
      .o_Pmod_Data(pdata), .o_Pmod_Frame(pframe), .o_Busy(busy)
   );

   pmod_link_scheduler #(.CLKS_PER_BIT(1), .DATA_W(8), .GAP_BITS(1)) dut_fast (
      .i_Clk(clk), .i_Rst(rst),
      .i_Req0(f_req0), .i_Data0(f_data0), .o_Ack0(f_ack0),
      .i_Req1(f_req1), .i_Data1(f_data1), .o_Ack1(f_ack1),
      .o_Pmod_Data(f_pdata), .o_Pmod_Frame(f_pframe), .o_Busy(f_busy)
   );

   // Expected {busy, frame, data} k cycles after the ack cycle of a frame carrying (d, tag).
   function automatic logic [2:0] exp_out(input logic [7:0] d, input logic tag, input int k,
                                          input int cpb, input int gap);
      logic [8:0] word;
      word = {d, tag};
      if (k < 9 * cpb) return {1'b1, 1'b1, word[k / cpb]};
      if (k < (9 + gap) * cpb) return 3'b100;
      return 3'b000;
   endfunction

   // Round-robin reference: lone requester wins, a tie goes to the one not served last.
   function automatic int pick(input logic r0, input logic r1);
      if (r0 && r1) return (model_last == 0) ? 1 : 0;
      if (r1) return 1;
      return 0;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      #3;
      tests_run++;
      if ({ack0, ack1, pdata, pframe, busy} !== 5'b0) begin
         tests_failed++;
         $display("FAIL reset_main got=%b exp=00000", {ack0, ack1, pdata, pframe, busy});
      end
      tests_run++;
      if ({f_ack0, f_ack1, f_pdata, f_pframe, f_busy} !== 5'b0) begin
         tests_failed++;
         $display("FAIL reset_fast got=%b exp=00000", {f_ack0, f_ack1, f_pdata, f_pframe, f_busy});
      end
      repeat (2) @(negedge clk);
      tests_run++;
      if ({ack0, ack1, pdata, pframe, busy} !== 5'b0) begin
         tests_failed++;
         $display("FAIL reset_held got=%b exp=00000", {ack0, ack1, pdata, pframe, busy});
      end
      rst = 1'b0;
      model_last = 1;
   endtask

   task automatic test_single0();
      logic [7:0] vals [3];
      logic [2:0] e;
      int hi;
      vals[0] = 8'h2A;
      vals[1] = 8'($urandom);
      vals[2] = 8'($urandom);
      for (int i = 0; i < 3; i++) begin
         data0 = vals[i];
         req0  = 1'b1;
         hi    = 0;
         for (int k = 0; k <= 26; k++) begin
            @(negedge clk);
            e = exp_out(vals[i], 1'b0, k, 2, 4);
            if (pframe === 1'b1) hi++;
            tests_run++;
            if ({busy, pframe, pdata} !== e) begin
               tests_failed++;
               $display("FAIL single0_out d=%h k=%0d got=%b exp=%b", vals[i], k, {busy, pframe, pdata}, e);
            end
            tests_run++;
            if (ack0 !== (k == 0) || ack1 !== 1'b0) begin
               tests_failed++;
               $display("FAIL single0_ack k=%0d got=%b%b exp=%b0", k, ack0, ack1, (k == 0));
            end
            if (k == 0) req0 = 1'b0;
         end
         tests_run++;
         if (hi !== 18) begin
            tests_failed++;
            $display("FAIL single0_framelen got=%0d exp=18", hi);
         end
         model_last = 0;
      end
   endtask

   task automatic test_single1();
      logic [7:0] vals [2];
      logic [2:0] e;
      vals[0] = 8'hFF;
      vals[1] = 8'($urandom);
      for (int i = 0; i < 2; i++) begin
         data1 = vals[i];
         req1  = 1'b1;
         for (int k = 0; k <= 26; k++) begin
            @(negedge clk);
            e = exp_out(vals[i], 1'b1, k, 2, 4);
            tests_run++;
            if ({busy, pframe, pdata} !== e) begin
               tests_failed++;
               $display("FAIL single1_out d=%h k=%0d got=%b exp=%b", vals[i], k, {busy, pframe, pdata}, e);
            end
            tests_run++;
            if (ack1 !== (k == 0) || ack0 !== 1'b0) begin
               tests_failed++;
               $display("FAIL single1_ack k=%0d got=%b%b exp=0%b", k, ack0, ack1, (k == 0));
            end
            if (k == 0) req1 = 1'b0;
         end
         model_last = 1;
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] e;
      int win, prev_ack, k;
      for (int run = 0; run < 2; run++) begin
         rst = 1'b1;
         @(negedge clk);
         data0 = (run == 0) ? 8'h01 : 8'($urandom);
         data1 = (run == 0) ? 8'h02 : 8'($urandom);
         req0 = 1'b1;
         req1 = 1'b1;
         rst = 1'b0;
         model_last = 1;
         prev_ack = -1;
         k = 0;
         for (int g = 0; g < 4; g++) begin
            win = pick(1'b1, 1'b1);
            model_last = win;
            for (int off = 0; off <= 26; off++) begin
               @(negedge clk);
               e = exp_out((win == 1) ? data1 : data0, win[0], off, 2, 4);
               tests_run++;
               if ({busy, pframe, pdata} !== e) begin
                  tests_failed++;
                  $display("FAIL b2b_out g=%0d off=%0d got=%b exp=%b", g, off, {busy, pframe, pdata}, e);
               end
               tests_run++;
               if (ack0 !== (off == 0 && win == 0) || ack1 !== (off == 0 && win == 1)) begin
                  tests_failed++;
                  $display("FAIL b2b_grant g=%0d off=%0d got=%b%b exp_winner=%0d", g, off, ack0, ack1, win);
               end
               if ((ack0 | ack1) === 1'b1) begin
                  if (prev_ack >= 0) begin
                     tests_run++;
                     if (k - prev_ack !== 27) begin
                        tests_failed++;
                        $display("FAIL b2b_spacing got=%0d exp=27", k - prev_ack);
                     end
                  end
                  prev_ack = k;
               end
               if (g == 3 && off == 0) begin
                  req0 = 1'b0;
                  req1 = 1'b0;
               end
               k++;
            end
         end
      end
   endtask

   task automatic test_random();
      logic [2:0] e;
      logic r0, r1;
      int win, mask;
      for (int i = 0; i < 12; i++) begin
         mask  = int'($urandom_range(1, 3));
         r0    = mask[0];
         r1    = mask[1];
         data0 = 8'($urandom);
         data1 = 8'($urandom);
         req0  = r0;
         req1  = r1;
         win   = pick(r0, r1);
         model_last = win;
         for (int off = 0; off <= 26; off++) begin
            @(negedge clk);
            e = exp_out((win == 1) ? data1 : data0, win[0], off, 2, 4);
            tests_run++;
            if ({busy, pframe, pdata} !== e) begin
               tests_failed++;
               $display("FAIL rand_out i=%0d off=%0d got=%b exp=%b", i, off, {busy, pframe, pdata}, e);
            end
            tests_run++;
            if (ack0 !== (off == 0 && win == 0) || ack1 !== (off == 0 && win == 1)) begin
               tests_failed++;
               $display("FAIL rand_grant i=%0d off=%0d req=%b%b got=%b%b exp_winner=%0d",
                        i, off, r1, r0, ack1, ack0, win);
            end
            if (off == 0) begin
               req0 = 1'b0;
               req1 = 1'b0;
            end
         end
      end
   endtask

   task automatic test_reset_midframe();
      logic [2:0] e;
      logic [7:0] d;
      d = 8'($urandom) | 8'h01;
      data0 = d;
      req0  = 1'b1;
      for (int k = 0; k <= 6; k++) begin
         @(negedge clk);
         e = exp_out(d, 1'b0, k, 2, 4);
         tests_run++;
         if ({busy, pframe, pdata} !== e || ack0 !== (k == 0)) begin
            tests_failed++;
            $display("FAIL midrst_pre k=%0d got=%b ack=%b exp=%b", k, {busy, pframe, pdata}, ack0, e);
         end
      end
      #2 rst = 1'b1;
      #1;
      tests_run++;
      if ({ack0, ack1, pdata, pframe, busy} !== 5'b0) begin
         tests_failed++;
         $display("FAIL midrst_drop got=%b exp=00000", {ack0, ack1, pdata, pframe, busy});
      end
      @(negedge clk);
      rst = 1'b0;
      model_last = 1;
      for (int k = 0; k <= 26; k++) begin
         @(negedge clk);
         e = exp_out(d, 1'b0, k, 2, 4);
         tests_run++;
         if ({busy, pframe, pdata} !== e) begin
            tests_failed++;
            $display("FAIL midrst_frame k=%0d got=%b exp=%b", k, {busy, pframe, pdata}, e);
         end
         tests_run++;
         if (ack0 !== (k == 0) || ack1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_ack k=%0d got=%b%b exp=%b0", k, ack0, ack1, (k == 0));
         end
         if (k == 0) req0 = 1'b0;
      end
      model_last = 0;
   endtask

   task automatic test_gap_drop();
      logic [2:0] e;
      logic [7:0] d;
      int up, dn;
      for (int i = 0; i < 3; i++) begin
         d  = 8'($urandom);
         up = int'($urandom_range(18, 21));
         dn = int'($urandom_range(up + 1, 25));
         data0 = d;
         data1 = 8'($urandom);
         req0  = 1'b1;
         for (int k = 0; k <= 31; k++) begin
            @(negedge clk);
            e = exp_out(d, 1'b0, k, 2, 4);
            tests_run++;
            if ({busy, pframe, pdata} !== e) begin
               tests_failed++;
               $display("FAIL gapdrop_out k=%0d got=%b exp=%b", k, {busy, pframe, pdata}, e);
            end
            tests_run++;
            if (ack1 !== 1'b0 || ack0 !== (k == 0)) begin
               tests_failed++;
               $display("FAIL gapdrop_ack k=%0d got=%b%b exp=0%b", k, ack1, ack0, (k == 0));
            end
            if (k == 0) req0 = 1'b0;
            if (k == up) req1 = 1'b1;
            if (k == dn) req1 = 1'b0;
         end
         model_last = 0;
      end
   endtask

   task automatic test_fast();
      logic [7:0] vals [3];
      logic [2:0] e;
      int hi;
      vals[0] = 8'h80;
      vals[1] = 8'($urandom);
      vals[2] = 8'($urandom);
      for (int i = 0; i < 3; i++) begin
         f_data0 = vals[i];
         f_req0  = 1'b1;
         hi      = 0;
         for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            e = exp_out(vals[i], 1'b0, k, 1, 1);
            if (f_pframe === 1'b1) hi++;
            tests_run++;
            if ({f_busy, f_pframe, f_pdata} !== e) begin
               tests_failed++;
               $display("FAIL fast_out d=%h k=%0d got=%b exp=%b", vals[i], k, {f_busy, f_pframe, f_pdata}, e);
            end
            tests_run++;
            if (f_ack0 !== (k == 0) || f_ack1 !== 1'b0) begin
               tests_failed++;
               $display("FAIL fast_ack k=%0d got=%b%b exp=%b0", k, f_ack0, f_ack1, (k == 0));
            end
            if (k == 0) f_req0 = 1'b0;
         end
         tests_run++;
         if (hi !== 9) begin
            tests_failed++;
            $display("FAIL fast_framelen got=%0d exp=9", hi);
         end
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_single0();
      test_single1();
      test_back_to_back();
      test_random();
      test_reset_midframe();
      test_gap_drop();
      test_fast();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout run did not complete");
      $fatal(1);
   end

endmodule
